// File: rtl/lw_hmac_feeder.sv
// Host-side feeder for the lightweight HMAC/SHA core: buffers message words, streams
// the key buffer and message with start/last framing, then returns the digest to the host.
module lw_hmac_feeder #(
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int DIGEST_WORDS = 8
) (
    input  logic                     clk_i,
    input  logic                     aresetn_i,
    input  logic                     cmd_valid_i,
    input  logic [1:0]               cmd_opcode_i,
    input  logic [15:0]              cmd_len_i,
    input  logic                     cmd_new_key_i,
    output logic                     cmd_ready_o,
    input  logic                     msg_valid_i,
    input  logic [WORD_SIZE-1:0]     msg_data_i,
    output logic                     msg_ready_o,
    input  logic                     key_wr_i,
    input  logic [3:0]               key_addr_i,
    input  logic [WORD_SIZE-1:0]     key_wdata_i,
    input  logic                     abort_i,
    output logic                     start_o,
    output logic                     last_o,
    output logic                     data_valid_o,
    output logic [WORD_SIZE-1:0]     data_o,
    output logic [1:0]               opcode_o,
    output logic [WORD_SIZE-1:0]     key_o,
    output logic                     key_valid_o,
    output logic                     new_key_o,
    output logic                     abort_o,
    input  logic                     ready_i,
    input  logic                     key_ready_i,
    input  logic                     core_ready_i,
    input  logic                     done_i,
    input  logic [8*WORD_SIZE-1:0]   hash_i,
    output logic                     dig_valid_o,
    output logic [WORD_SIZE-1:0]     dig_data_o,
    input  logic                     dig_ready_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [2:0]               dbg_state_o
);

    // Handshakes: a word moves on a cycle where its valid and the matching ready are both
    // high at the rising edge; valid never waits on ready, and start_o is never a transfer.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [WORD_SIZE-1:0] KEY_RST = {(WORD_SIZE/2){2'b01}};
    localparam logic [2:0] DIG_LAST = 3'(DIGEST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_KEY   = 3'd2,
        S_DATA  = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WORD_SIZE-1:0] r_fifo [FIFO_DEPTH];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [WORD_SIZE-1:0] r_key_buf [16];
    logic [WORD_SIZE-1:0] r_digest [8];
    logic [1:0]           r_opcode;
    logic                 r_new_key;
    logic [15:0]          r_rem;
    logic [3:0]           r_kidx;
    logic [2:0]           r_didx;
    logic                 r_err;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_accept;
    logic                 w_err_set;
    logic                 w_key_xfer;
    logic                 w_dig_xfer;
    logic                 w_capture;
    logic [WORD_SIZE-1:0] w_head;

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head      = r_fifo[r_rptr[AW-1:0]];
    assign w_push      = msg_valid_i && !w_full && !w_flush;
    assign msg_ready_o = !w_full;
    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_err_set    = 1'b0;
        w_flush      = 1'b0;
        w_pop        = 1'b0;
        w_key_xfer   = 1'b0;
        w_dig_xfer   = 1'b0;
        w_capture    = 1'b0;
        start_o      = 1'b0;
        last_o       = 1'b0;
        data_valid_o = 1'b0;
        data_o       = '0;
        opcode_o     = '0;
        new_key_o    = 1'b0;
        key_valid_o  = 1'b0;
        key_o        = '0;
        abort_o      = 1'b0;
        dig_valid_o  = 1'b0;
        dig_data_o   = '0;
        // A host abort outranks an early done, and both cancel any transfer this cycle.
        if (r_state != S_IDLE && abort_i) begin
            abort_o = 1'b1;
            w_flush = 1'b1;
            w_next  = S_IDLE;
        end else if ((r_state == S_START || r_state == S_KEY || r_state == S_DATA) && done_i) begin
            abort_o   = 1'b1;
            w_flush   = 1'b1;
            w_err_set = 1'b1;
            w_next    = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_len_i == 16'd0) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_accept = 1'b1;
                            w_next   = S_START;
                        end
                    end
                end
                S_START: begin
                    if (core_ready_i && !w_empty) begin
                        start_o      = 1'b1;
                        data_valid_o = 1'b1;
                        data_o       = w_head;
                        opcode_o     = r_opcode;
                        new_key_o    = r_new_key;
                        w_next       = (r_opcode[0] && r_new_key) ? S_KEY : S_DATA;
                    end
                end
                S_KEY: begin
                    key_valid_o = 1'b1;
                    key_o       = r_key_buf[r_kidx];
                    if (key_ready_i) begin
                        w_key_xfer = 1'b1;
                        if (r_kidx == 4'd0) begin
                            w_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (!w_empty) begin
                        data_valid_o = 1'b1;
                        data_o       = w_head;
                        last_o       = (r_rem == 16'd1);
                        if (ready_i) begin
                            w_pop = 1'b1;
                            if (r_rem == 16'd1) begin
                                w_next = S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (done_i) begin
                        w_capture = 1'b1;
                        w_next    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    dig_valid_o = 1'b1;
                    dig_data_o  = r_digest[r_didx];
                    if (dig_ready_i) begin
                        w_dig_xfer = 1'b1;
                        if (r_didx == DIG_LAST) begin
                            w_next = S_IDLE;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr[AW-1:0]] <= msg_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < 16; i++) r_key_buf[i] <= KEY_RST;
        end else if (key_wr_i && r_state == S_IDLE) begin
            r_key_buf[key_addr_i] <= key_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < 8; i++) r_digest[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < 8; i++) r_digest[i] <= hash_i[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_opcode  <= '0;
            r_new_key <= 1'b0;
            r_rem     <= '0;
            r_kidx    <= '0;
            r_didx    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opcode  <= cmd_opcode_i;
                r_new_key <= cmd_new_key_i;
                r_rem     <= cmd_len_i;
                r_kidx    <= 4'd15;
                r_err     <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_pop)      r_rem  <= r_rem - 16'd1;
            if (w_key_xfer) r_kidx <= r_kidx - 4'd1;
            if (w_capture)  r_didx <= 3'd0;
            if (w_dig_xfer) r_didx <= r_didx + 3'd1;
        end
    end

endmodule

// File: tb/tb_lw_hmac_feeder.sv
// Bench for lw_hmac_feeder: emulates the host and the HMAC core cycle by cycle and compares
// what the feeder emits against queues built from the message, key and hash it was given.
module tb_lw_hmac_feeder;
    localparam int W  = 32;
    localparam int DW = 8;

    logic           clk_i = 1'b0;
    logic           aresetn_i = 1'b0;
    logic           cmd_valid_i = 1'b0, cmd_new_key_i = 1'b0;
    logic [1:0]     cmd_opcode_i = '0;
    logic [15:0]    cmd_len_i = '0;
    logic           cmd_ready_o;
    logic           msg_valid_i = 1'b0;
    logic [W-1:0]   msg_data_i = '0;
    logic           msg_ready_o;
    logic           key_wr_i = 1'b0;
    logic [3:0]     key_addr_i = '0;
    logic [W-1:0]   key_wdata_i = '0;
    logic           abort_i = 1'b0;
    logic           start_o, last_o, data_valid_o, key_valid_o, new_key_o, abort_o;
    logic [W-1:0]   data_o, key_o, dig_data_o;
    logic [1:0]     opcode_o;
    logic           ready_i = 1'b0, key_ready_i = 1'b0, core_ready_i = 1'b1, done_i = 1'b0;
    logic [8*W-1:0] hash_i = '0;
    logic           dig_valid_o, dig_ready_i = 1'b0;
    logic           busy_o, err_o;
    logic [2:0]     dbg_state_o;

    lw_hmac_feeder #(.WORD_SIZE(W), .FIFO_DEPTH(8), .DIGEST_WORDS(DW)) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_opcode_i(cmd_opcode_i), .cmd_len_i(cmd_len_i),
        .cmd_new_key_i(cmd_new_key_i), .cmd_ready_o(cmd_ready_o),
        .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_ready_o(msg_ready_o),
        .key_wr_i(key_wr_i), .key_addr_i(key_addr_i), .key_wdata_i(key_wdata_i),
        .abort_i(abort_i), .start_o(start_o), .last_o(last_o), .data_valid_o(data_valid_o),
        .data_o(data_o), .opcode_o(opcode_o), .key_o(key_o), .key_valid_o(key_valid_o),
        .new_key_o(new_key_o), .abort_o(abort_o), .ready_i(ready_i), .key_ready_i(key_ready_i),
        .core_ready_i(core_ready_i), .done_i(done_i), .hash_i(hash_i),
        .dig_valid_o(dig_valid_o), .dig_data_o(dig_data_o), .dig_ready_i(dig_ready_i),
        .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] key_model [16];
    logic [W-1:0] hash_w [8];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] stim_q [$];

    // Observed traffic
    logic [W-1:0] obs_data_q [$];
    logic         obs_last_q [$];
    logic [W-1:0] obs_key_q [$];
    logic [W-1:0] obs_dig_q [$];
    int           start_cnt, abort_cnt, overlap_cnt, abort_cyc, idle_cyc;
    logic [W-1:0] start_data;
    logic         start_nk;
    logic [1:0]   start_op;

    task automatic reset_key_model();
        for (int i = 0; i < 16; i++) key_model[i] = 32'h5555_5555;
    endtask

    task automatic write_key(input logic [3:0] a, input logic [W-1:0] d);
        key_wr_i = 1'b1; key_addr_i = a; key_wdata_i = d;
        @(posedge clk_i); #1;
        key_wr_i = 1'b0;
        key_model[a] = d;
    endtask

    // Runs one command end to end. abort_left >= 0 aborts with that many words still unsent;
    // early_done pulses done after the first data transfer.
    task automatic run_txn(input logic [1:0] op, input logic nk, input int len, input int rdy_mode,
                           input int pre, input int abort_left, input bit early_done, input bit do_keywr);
        logic [W-1:0] pend_q [$];
        logic [W-1:0] w;
        int guard = 0;
        int done_cd = -1;
        bit done_sched = 0;
        bit stop = 0;
        bit fin = 0;
        obs_data_q.delete(); obs_last_q.delete(); obs_key_q.delete(); obs_dig_q.delete();
        exp_q.delete();
        start_cnt = 0; abort_cnt = 0; overlap_cnt = 0; abort_cyc = -1; idle_cyc = -1;
        for (int i = 0; i < len; i++) begin
            w = (i < stim_q.size()) ? stim_q[i] : $urandom;
            exp_q.push_back(w);
            pend_q.push_back(w);
        end
        stim_q.delete();
        while (pend_q.size() > len - pre && guard < 50) begin
            msg_valid_i = 1'b1; msg_data_i = pend_q[0];
            @(negedge clk_i);
            if (msg_ready_o) void'(pend_q.pop_front());
            @(posedge clk_i); #1;
            guard++;
        end
        msg_valid_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_len_i = 16'(len); cmd_new_key_i = nk;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            ready_i      = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            core_ready_i = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            key_ready_i  = 1'($urandom_range(0, 1));
            dig_ready_i  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (abort_left >= 0 && !stop && start_cnt > 0 && obs_data_q.size() == len - abort_left) begin
                abort_i = 1'b1; stop = 1;
            end else begin
                abort_i = 1'b0;
            end
            msg_valid_i = (pend_q.size() > 0) && !stop && (rdy_mode != 1 || c % 3 == 0);
            msg_data_i  = (pend_q.size() > 0) ? pend_q[0] : '0;
            if (done_cd == 0) begin
                done_i = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    hash_w[k] = $urandom;
                    hash_i[k*W +: W] = hash_w[k];
                end
            end else begin
                done_i = 1'b0;
            end
            if (done_cd >= 0) done_cd--;
            if (do_keywr) begin
                key_wr_i = 1'($urandom_range(0, 1)); key_addr_i = 4'($urandom); key_wdata_i = $urandom;
            end
            @(negedge clk_i);
            if (start_o) begin
                start_cnt++; start_data = data_o; start_nk = new_key_o; start_op = opcode_o;
            end
            if (data_valid_o && ready_i && !start_o) begin
                obs_data_q.push_back(data_o); obs_last_q.push_back(last_o);
            end
            if (key_valid_o && key_ready_i) obs_key_q.push_back(key_o);
            if (key_valid_o && data_valid_o) overlap_cnt++;
            if (dig_valid_o && dig_ready_i) obs_dig_q.push_back(dig_data_o);
            if (abort_o) begin abort_cnt++; abort_cyc = c; end
            if (msg_valid_i && msg_ready_o) void'(pend_q.pop_front());
            if (!busy_o) begin
                fin = 1; idle_cyc = c; key_wr_i = 1'b0; msg_valid_i = 1'b0;
            end
            if (!stop && !done_sched && obs_data_q.size() == len) begin done_sched = 1; done_cd = 2; end
            if (early_done && !stop && obs_data_q.size() == 1) begin stop = 1; done_cd = 0; end
            if (!fin) begin @(posedge clk_i); #1; end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL txn_timeout: busy_o=%0b after 3000 cycles, expected 0", busy_o);
        end
        msg_valid_i = 1'b0; abort_i = 1'b0; done_i = 1'b0; key_wr_i = 1'b0;
        ready_i = 1'b0; key_ready_i = 1'b0; dig_ready_i = 1'b0; core_ready_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        aresetn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || msg_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b msg_ready=%b busy=%b, expected 1 1 0", cmd_ready_o, msg_ready_o, busy_o);
        end
        checks++;
        if ({start_o, last_o, data_valid_o, key_valid_o, new_key_o, abort_o, dig_valid_o, err_o} !== 8'h00 ||
            data_o !== '0 || key_o !== '0 || dig_data_o !== '0 || opcode_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: strobes=%b data=%h key=%h dig=%h op=%b, expected all zero",
                     {start_o, last_o, data_valid_o, key_valid_o, new_key_o, abort_o, dig_valid_o, err_o},
                     data_o, key_o, dig_data_o, opcode_o);
        end
        @(posedge clk_i); #1;
        aresetn_i = 1'b1;
        reset_key_model();
        @(posedge clk_i); #1;
    endtask

    task automatic test_sha_basic();
        stim_q = '{32'h6162_6380, 32'h0000_0000, 32'h0000_0018};
        run_txn(2'b00, 1'b0, 3, 0, 3, -1, 0, 0);
        checks++;
        if (start_cnt != 1 || start_data !== 32'h6162_6380 || obs_key_q.size() != 0) begin
            errors++;
            $display("FAIL sha_start: starts=%0d head=%h keys=%0d, expected 1 61626380 0", start_cnt, start_data, obs_key_q.size());
        end
        checks++;
        if (obs_data_q.size() != 3) begin
            errors++; $display("FAIL sha_count: got %0d words, expected 3", obs_data_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
            checks++;
            if (obs_data_q[i] !== exp_q[i] || obs_last_q[i] !== (i == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL sha_word%0d: got %h last=%b, expected %h last=%b", i, obs_data_q[i], obs_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        checks++;
        if (obs_dig_q.size() != DW) begin
            errors++; $display("FAIL sha_dig_count: got %0d digest words, expected %0d", obs_dig_q.size(), DW);
        end
        for (int k = 0; k < DW; k++) begin
            checks++;
            if (k >= obs_dig_q.size() || obs_dig_q[k] !== hash_w[k]) begin
                errors++;
                $display("FAIL sha_dig%0d: got %h, expected %h", k, (k < obs_dig_q.size()) ? obs_dig_q[k] : 32'hx, hash_w[k]);
            end
        end
    endtask

    task automatic test_hmac_new_key(input bit write_idx);
        if (write_idx) for (int i = 0; i < 16; i++) write_key(4'(i), 32'(i));
        run_txn(2'b01, 1'b1, 4, 2, 2, -1, 0, 1);
        checks++;
        if (start_cnt != 1 || start_nk !== 1'b1 || start_op !== 2'b01 || overlap_cnt != 0) begin
            errors++;
            $display("FAIL hmac_start: starts=%0d new_key=%b op=%b overlap=%0d, expected 1 1 01 0", start_cnt, start_nk, start_op, overlap_cnt);
        end
        checks++;
        if (obs_key_q.size() != 16) begin
            errors++; $display("FAIL hmac_key_count: got %0d key words, expected 16", obs_key_q.size());
        end
        for (int i = 0; i < 16 && i < obs_key_q.size(); i++) begin
            checks++;
            if (obs_key_q[i] !== key_model[15 - i]) begin
                errors++; $display("FAIL hmac_key%0d: got %h, expected %h", i, obs_key_q[i], key_model[15 - i]);
            end
        end
        checks++;
        if (obs_data_q.size() != exp_q.size() || obs_data_q != exp_q) begin
            errors++; $display("FAIL hmac_data: got %0d words (first %h), expected %0d words (first %h)",
                               obs_data_q.size(), (obs_data_q.size() > 0) ? obs_data_q[0] : 32'hx, exp_q.size(), exp_q[0]);
        end
        checks++;
        if (obs_dig_q.size() != DW || obs_dig_q[DW-1] !== hash_w[DW-1]) begin
            errors++; $display("FAIL hmac_digest: got %0d words, expected %0d ending %h", obs_dig_q.size(), DW, hash_w[DW-1]);
        end
    endtask

    task automatic test_saved_key();
        run_txn(2'b11, 1'b0, 5, 2, 3, -1, 0, 0);
        checks++;
        if (obs_key_q.size() != 0 || start_nk !== 1'b0 || start_op !== 2'b11 || start_cnt != 1) begin
            errors++;
            $display("FAIL saved_key: keys=%0d new_key=%b op=%b starts=%0d, expected 0 0 11 1", obs_key_q.size(), start_nk, start_op, start_cnt);
        end
        checks++;
        if (obs_data_q != exp_q || obs_last_q.size() != 5 || obs_last_q[4] !== 1'b1) begin
            errors++; $display("FAIL saved_data: got %0d words, expected %0d with last on word 4", obs_data_q.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        run_txn(2'b00, 1'b0, 5, 1, 1, -1, 0, 0);
        checks++;
        if (obs_data_q.size() != 5) begin
            errors++; $display("FAIL bp_count: got %0d words, expected 5", obs_data_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
            checks++;
            if (obs_data_q[i] !== exp_q[i] || obs_last_q[i] !== (i == 4)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h last=%b, expected %h last=%b", i, obs_data_q[i], obs_last_q[i], exp_q[i], i == 4);
            end
        end
        checks++;
        if (obs_dig_q.size() != DW || obs_dig_q[0] !== hash_w[0]) begin
            errors++; $display("FAIL bp_digest: got %0d words, expected %0d starting %h", obs_dig_q.size(), DW, hash_w[0]);
        end
    endtask

    task automatic test_abort();
        run_txn(2'b00, 1'b0, 6, 0, 6, 2, 0, 0);
        checks++;
        if (abort_cnt != 1 || obs_data_q.size() != 4 || obs_dig_q.size() != 0) begin
            errors++;
            $display("FAIL abort_pulse: aborts=%0d words=%0d digest=%0d, expected 1 4 0", abort_cnt, obs_data_q.size(), obs_dig_q.size());
        end
        checks++;
        if (idle_cyc != abort_cyc + 1) begin
            errors++; $display("FAIL abort_idle: idle at cycle %0d, expected %0d", idle_cyc, abort_cyc + 1);
        end
        run_txn(2'b00, 1'b0, 3, 0, 3, -1, 0, 0);
        checks++;
        if (obs_data_q != exp_q) begin
            errors++; $display("FAIL abort_flush: got first word %h, expected %h",
                               (obs_data_q.size() > 0) ? obs_data_q[0] : 32'hx, exp_q[0]);
        end
    endtask

    task automatic test_len_zero();
        int bad = 0;
        cmd_valid_i = 1'b1; cmd_opcode_i = 2'b01; cmd_len_i = 16'd0; cmd_new_key_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (start_o || busy_o || key_valid_o) bad++;
        end
        checks++;
        if (err_o !== 1'b1 || bad != 0) begin
            errors++; $display("FAIL len_zero: err=%b bad_cycles=%0d, expected 1 0", err_o, bad);
        end
        @(posedge clk_i); #1;
        run_txn(2'b00, 1'b0, 2, 0, 2, -1, 0, 0);
        checks++;
        if (err_o !== 1'b0 || obs_data_q != exp_q) begin
            errors++; $display("FAIL len_zero_clear: err=%b words=%0d, expected 0 %0d", err_o, obs_data_q.size(), exp_q.size());
        end
    endtask

    task automatic test_done_early();
        run_txn(2'b00, 1'b0, 4, 0, 4, -1, 1, 0);
        checks++;
        if (err_o !== 1'b1 || abort_cnt != 1 || obs_dig_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL done_early: err=%b aborts=%0d digest=%0d busy=%b, expected 1 1 0 0", err_o, abort_cnt, obs_dig_q.size(), busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic       nk;
        int         len;
        int         nkeys;
        for (int t = 0; t < 6; t++) begin
            op  = 2'($urandom);
            nk  = 1'($urandom);
            len = $urandom_range(1, 20);
            run_txn(op, nk, len, 2, $urandom_range(0, (len < 8) ? len : 8), -1, 0, 1);
            nkeys = (op[0] && nk) ? 16 : 0;
            checks++;
            if (obs_data_q != exp_q || obs_last_q.size() != len || obs_last_q[len-1] !== 1'b1) begin
                errors++; $display("FAIL b2b%0d_data: got %0d words, expected %0d", t, obs_data_q.size(), len);
            end
            checks++;
            if (obs_last_q.sum() with (int'(item)) != 1) begin
                errors++; $display("FAIL b2b%0d_last: last asserted on %0d transfers, expected 1", t, obs_last_q.sum() with (int'(item)));
            end
            checks++;
            if (obs_key_q.size() != nkeys || (nkeys == 16 && obs_key_q[0] !== key_model[15])) begin
                errors++; $display("FAIL b2b%0d_keys: got %0d key words, expected %0d", t, obs_key_q.size(), nkeys);
            end
            checks++;
            if (obs_dig_q.size() != DW || obs_dig_q[3] !== hash_w[3] || err_o !== 1'b0) begin
                errors++; $display("FAIL b2b%0d_digest: got %0d words err=%b, expected %0d err=0", t, obs_dig_q.size(), err_o, DW);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            msg_valid_i = 1'b1; msg_data_i = $urandom;
            @(posedge clk_i); #1;
        end
        msg_valid_i = 1'b0;
        core_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_opcode_i = 2'b01; cmd_len_i = 16'd4; cmd_new_key_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 aresetn_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || msg_ready_o !== 1'b1) begin
            errors++; $display("FAIL async_reset: busy=%b cmd_ready=%b msg_ready=%b, expected 0 1 1", busy_o, cmd_ready_o, msg_ready_o);
        end
        @(posedge clk_i); #1;
        aresetn_i = 1'b1;
        core_ready_i = 1'b1;
        reset_key_model();
        @(posedge clk_i); #1;
        run_txn(2'b01, 1'b1, 3, 0, 3, -1, 0, 0);
        checks++;
        if (obs_data_q != exp_q || obs_key_q.size() != 16 || obs_key_q[0] !== 32'h5555_5555) begin
            errors++;
            $display("FAIL async_after: words=%0d keys=%0d key0=%h, expected %0d 16 55555555",
                     obs_data_q.size(), obs_key_q.size(), (obs_key_q.size() > 0) ? obs_key_q[0] : 32'hx, exp_q.size());
        end
    endtask

    initial begin
        reset_key_model();
        test_reset();
        test_sha_basic();
        test_hmac_new_key(0);
        test_hmac_new_key(1);
        test_saved_key();
        test_backpressure();
        test_abort();
        test_len_zero();
        test_done_early();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
